// File: rtl/load_fu_ctrl.sv
// Load functional-unit controller: round-robin picks one busy load RS line, reads the
// word from data memory, extends the byte/half/word and broadcasts it on the CDB.
//
// state | meaning
// IDLE  | scan load lines from rr_ptr for a busy one
// REQ   | mem_req held with a stable mem_addr until mem_gnt
// WAIT  | request accepted, waiting for mem_rvalid
// BCAST | cdb_req held with a stable cdb until cdb_gnt
module load_fu_ctrl #(
  parameter int         NUM_LINES = 2,
  parameter logic [7:0] TAG_BASE  = 8'h10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LINES-1:0]     line_busy,
  input  logic [32*NUM_LINES-1:0]  line_addr,
  input  logic [3*NUM_LINES-1:0]   line_type,
  output logic [NUM_LINES-1:0]     FU_result_taken,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  output logic [40:0]              cdb
);

  localparam int SEL_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, BCAST} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] sel;
  logic [1:0]       lat_lo;
  logic [2:0]       lat_type;

  logic             hit;
  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] next_ptr;
  logic [31:0]      pick_addr;
  logic [2:0]       pick_type;
  logic [31:0]      ext_data;
  logic [7:0]       ext_byte;
  logic [15:0]      ext_half;
  logic [7:0]       cur_tag;

  // Walk offsets from the far end down so the line nearest rr_ptr wins.
  always_comb begin
    int j;
    j    = 0;
    hit  = 1'b0;
    pick = '0;
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_LINES) j = j - NUM_LINES;
      if (line_busy[j]) begin
        hit  = 1'b1;
        pick = SEL_W'(j);
      end
    end
  end

  always_comb begin
    pick_addr = line_addr[32*int'(pick) +: 32];
    pick_type = line_type[3*int'(pick) +: 3];
    if (int'(pick) == NUM_LINES - 1) next_ptr = '0;
    else                             next_ptr = pick + SEL_W'(1);
  end

  always_comb begin
    ext_byte = 8'h00;
    ext_half = 16'h0000;
    ext_data = mem_rdata;
    case (lat_lo)
      2'd0:    ext_byte = mem_rdata[7:0];
      2'd1:    ext_byte = mem_rdata[15:8];
      2'd2:    ext_byte = mem_rdata[23:16];
      default: ext_byte = mem_rdata[31:24];
    endcase
    ext_half = lat_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_type[1:0])
      2'b00:   ext_data = {{24{~lat_type[2] & ext_byte[7]}}, ext_byte};
      2'b01:   ext_data = {{16{~lat_type[2] & ext_half[15]}}, ext_half};
      default: ext_data = mem_rdata;
    endcase
  end

  assign cur_tag = TAG_BASE + 8'(sel);

  // The taken pulse follows the grant within the same cycle so the RS line frees on this edge.
  always_comb begin
    FU_result_taken = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      FU_result_taken[i] = (state == BCAST) && cdb_gnt && (int'(sel) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      lat_lo   <= 2'b00;
      lat_type <= 3'b000;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      cdb_req  <= 1'b0;
      cdb      <= 41'h0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            sel      <= pick;
            rr_ptr   <= next_ptr;
            lat_lo   <= pick_addr[1:0];
            lat_type <= pick_type;
            mem_addr <= {pick_addr[31:2], 2'b00};
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            cdb_req <= 1'b1;
            cdb     <= {1'b1, cur_tag, ext_data};
            state   <= BCAST;
          end
        end
        BCAST: begin
          if (cdb_gnt) begin
            cdb_req <= 1'b0;
            cdb     <= 41'h0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
